cla_seq_adder_ctrl: RTL and testbench

Multi-cycle sequencer that computes a WIDTH-bit sum using one shared 5-bit carry-lookahead slice, one slice per clock, LSB slice first. It captures operands on a valid/ready handshake and feeds 5-bit chunks plus a registered carry into the slice. It returns the WIDTH+1-bit result, including carry-out, on a second valid/ready handshake. It sits between a requester and the adder datapath, so wide additions reuse the 5-bit CLA hardware.

---
 rtl/cla_seq_adder_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cla_seq_adder_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder_ctrl.sv
// ============================================================================
// Module   : cla_seq_adder_ctrl
// Brief    : Multi-cycle WIDTH-bit adder sequencer over one shared 5-bit CLA
//            slice, LSB slice first, valid/ready on both request and result.
//            Optional subtract mode enabled by macro CLA_SEQ_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_seq_adder_ctrl #(
    parameter int WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
`ifdef CLA_SEQ_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_busy
);

    localparam int SLICE_W = 5;
    localparam int NSLICE  = (WIDTH + SLICE_W - 1) / SLICE_W;
    localparam int PW      = NSLICE * SLICE_W;
    localparam int c_IW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_a;
    logic [PW-1:0]     r_b;
    logic              r_carry;
    logic [c_IW-1:0]   r_idx;
    logic [WIDTH:0]    r_res;
    logic [WIDTH:0]    w_res_nxt;
    logic              w_sub;
    logic [WIDTH-1:0]  w_b_cap;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;
    logic [SLICE_W-1:0] w_sum;
    logic              w_last;

`ifdef CLA_SEQ_SUB_EN
    assign w_sub = i_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is A + ~B + 1; padding bits above WIDTH stay zero.
    assign w_b_cap = w_sub ? ~i_add2 : i_add2;
    assign w_last  = (r_idx == c_LAST);

    // Operands shift down one slice per RUN edge, so the active chunk is
    // always in the low SLICE_W bits.
    assign w_g = r_a[SLICE_W-1:0] & r_b[SLICE_W-1:0];
    assign w_p = r_a[SLICE_W-1:0] ^ r_b[SLICE_W-1:0];

    // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0]
    always_comb begin : cla_carry
        logic w_pp;
        w_c    = '0;
        w_pp   = 1'b0;
        w_c[0] = r_carry;
        for (int i = 0; i < SLICE_W; i++) begin
            w_c[i+1] = w_g[i];
            w_pp     = w_p[i];
            for (int k = i - 1; k >= 0; k--) begin
                w_c[i+1] = w_c[i+1] | (w_pp & w_g[k]);
                w_pp     = w_pp & w_p[k];
            end
            w_c[i+1] = w_c[i+1] | (w_pp & w_c[0]);
        end
    end

    assign w_sum = w_p ^ w_c[SLICE_W-1:0];

    // Bit WIDTH comes from the padded top slice, or from the slice carry-out
    // when WIDTH is an exact multiple of the slice width.
    always_comb begin
        w_res_nxt = r_res;
        for (int j = 0; j <= WIDTH; j++) begin
            if (j < PW) begin
                if (int'(r_idx) == (j / SLICE_W)) begin
                    w_res_nxt[j] = w_sum[j % SLICE_W];
                end
            end else if (w_last) begin
                w_res_nxt[j] = w_c[SLICE_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a     <= PW'(i_add1);
                        r_b     <= PW'(w_b_cap);
                        r_carry <= w_sub;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_carry <= w_c[SLICE_W];
                    r_res   <= w_res_nxt;
                    r_idx   <= r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = r_res;

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder_ctrl.sv
// ============================================================================
// Module   : tb_cla_seq_adder_ctrl
// Brief    : Directed self-checking bench for cla_seq_adder_ctrl, WIDTH=20
//            and WIDTH=7 instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_seq_adder_ctrl;

    logic        clk;
    logic        rst;

    logic        valid;
    logic        ready_o;
    logic [19:0] add1;
    logic [19:0] add2;
    logic        vout;
    logic        rdy_in;
    logic [20:0] result;
    logic        busy;

    logic        s7_valid;
    logic        s7_ready_o;
    logic [6:0]  s7_add1;
    logic [6:0]  s7_add2;
    logic        s7_vout;
    logic        s7_rdy_in;
    logic [7:0]  s7_result;
    logic        s7_busy;

`ifdef CLA_SEQ_SUB_EN
    logic        sub;
`endif

    int n_assert;
    int n_fail;

    cla_seq_adder_ctrl #(.WIDTH(20)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .o_ready  (ready_o),
        .i_add1   (add1),
        .i_add2   (add2),
`ifdef CLA_SEQ_SUB_EN
        .i_sub    (sub),
`endif
        .o_valid  (vout),
        .i_ready  (rdy_in),
        .o_result (result),
        .o_busy   (busy)
    );

    cla_seq_adder_ctrl #(.WIDTH(7)) dut7 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (s7_valid),
        .o_ready  (s7_ready_o),
        .i_add1   (s7_add1),
        .i_add2   (s7_add2),
`ifdef CLA_SEQ_SUB_EN
        .i_sub    (1'b0),
`endif
        .o_valid  (s7_vout),
        .i_ready  (s7_rdy_in),
        .o_result (s7_result),
        .o_busy   (s7_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=20 transaction; entered and left #1 after a rising edge in IDLE.
    task automatic do_op(input logic [19:0] a, input logic [19:0] b, input logic s,
                         input logic [20:0] exp, input string tag,
                         input bit chk_c, input int hold);
        valid = 1'b1;
        add1  = a;
        add2  = b;
`ifdef CLA_SEQ_SUB_EN
        sub   = s;
`endif
        @(posedge clk); #1;
        check({tag, "/accept_ready"}, 64'(ready_o), 64'd0);
        check({tag, "/accept_busy"}, 64'(busy), 64'd1);
        valid = 1'b0;
        add1  = ~a;
        add2  = ~b;
`ifdef CLA_SEQ_SUB_EN
        sub   = ~s;
`endif
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (chk_c) check({tag, "/carry_reg"}, 64'(dut.r_carry), 64'd1);
            check({tag, "/valid_timing"}, 64'(vout), 64'(k == 4));
        end
        check({tag, "/result"}, 64'(result), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, 64'(vout), 64'd1);
            check({tag, "/hold_result"}, 64'(result), 64'(exp));
            check({tag, "/hold_ready"}, 64'(ready_o), 64'd0);
        end
        rdy_in = 1'b1;
        @(posedge clk); #1;
        check({tag, "/drop_valid"}, 64'(vout), 64'd0);
        check({tag, "/idle_ready"}, 64'(ready_o), 64'd1);
        check({tag, "/idle_busy"}, 64'(busy), 64'd0);
        check({tag, "/result_kept"}, 64'(result), 64'(exp));
        rdy_in = 1'b0;
    endtask

    task automatic do_op7(input logic [6:0] a, input logic [6:0] b,
                          input logic [7:0] exp, input string tag);
        s7_valid = 1'b1;
        s7_add1  = a;
        s7_add2  = b;
        @(posedge clk); #1;
        check({tag, "/accept_ready"}, 64'(s7_ready_o), 64'd0);
        s7_valid = 1'b0;
        s7_add1  = ~a;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            check({tag, "/valid_timing"}, 64'(s7_vout), 64'(k == 2));
        end
        check({tag, "/result"}, 64'(s7_result), 64'(exp));
        s7_rdy_in = 1'b1;
        @(posedge clk); #1;
        check({tag, "/drop_valid"}, 64'(s7_vout), 64'd0);
        check({tag, "/idle_ready"}, 64'(s7_ready_o), 64'd1);
        s7_rdy_in = 1'b0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        valid     = 1'b0;
        add1      = '0;
        add2      = '0;
        rdy_in    = 1'b0;
        s7_valid  = 1'b0;
        s7_add1   = '0;
        s7_add2   = '0;
        s7_rdy_in = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset/ready", 64'(ready_o), 64'd1);
        check("reset/valid", 64'(vout), 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/result", 64'(result), 64'd0);
        check("reset/w7_result", 64'(s7_result), 64'd0);
        rst = 1'b0;

        do_op(20'h00003, 20'h00004, 1'b0, 21'h000007, "basic", 1'b0, 0);

        // i_ready high while idle must not disturb anything
        rdy_in = 1'b1;
        @(posedge clk); #1;
        check("idle_ready_noeffect/valid", 64'(vout), 64'd0);
        check("idle_ready_noeffect/ready", 64'(ready_o), 64'd1);
        rdy_in = 1'b0;

        do_op(20'hFFFFF, 20'h00001, 1'b0, 21'h100000, "ripple", 1'b1, 0);
        do_op(20'hABCDE, 20'h12345, 1'b0, 21'h0BE023, "mixed", 1'b0, 0);
        do_op(20'hFFFFF, 20'hFFFFF, 1'b0, 21'h1FFFFE, "max_backpressure", 1'b0, 10);

        // Abort: reset sampled on the second RUN edge after accept.
        valid = 1'b1;
        add1  = 20'h12345;
        add2  = 20'h54321;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort/ready", 64'(ready_o), 64'd1);
        check("abort/busy", 64'(busy), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("abort/no_valid", 64'(vout), 64'd0);
        end
        do_op(20'h12345, 20'h54321, 1'b0, 21'h066666, "after_abort", 1'b0, 0);

        do_op7(7'h7F, 7'h01, 8'h80, "w7_carry");
        do_op7(7'h7F, 7'h7F, 8'hFE, "w7_max");
        do_op7(7'h12, 7'h34, 8'h46, "w7_small");

`ifdef CLA_SEQ_SUB_EN
        do_op(20'h00005, 20'h00007, 1'b1, 21'h0FFFFE, "sub_borrow", 1'b0, 0);
        do_op(20'h00007, 20'h00005, 1'b1, 21'h100002, "sub_noborrow", 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
